temp_sample_scheduler: RTL and testbench



---
 rtl/temp_sample_scheduler.sv | 167 ++++++++++++++++
 tb/tb_temp_sample_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/temp_sample_scheduler.sv
// rtl/temp_sample_scheduler.sv - periodic SPI temperature read sequencer with ms time base
// Optional read watchdog enabled by defining SCHED_TIMEOUT_EN.
module temp_sample_scheduler #(
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 100_000
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              en_in,
    input  logic [15:0]       period_ms_in,
    output logic              spi_start_out,
    input  logic              spi_busy_in,
    input  logic              spi_done_in,
    input  logic [DATA_W-1:0] spi_data_in,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid_out,
    output logic              overrun_out,
    output logic              timeout_err_out,
    input  logic              clr_err_in
);

    localparam int TICKS_PER_MS = CLK_FREQ_HZ / 1000;
    localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_MS - 1);

    if (TICKS_PER_MS < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("temp_sample_scheduler: unsupported clock frequency or timeout");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        START     = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [PW-1:0] presc;
    logic [15:0]   ms_cnt;
    logic [15:0]   ms_max;
    logic [15:0]   period_max;
    logic          tick;
    logic          capture;
    logic          timeout_hit;

    // A programmed period of 0 behaves as 1 ms.
    assign period_max = (period_ms_in == 16'd0) ? 16'd0 : period_ms_in - 16'd1;
    assign tick       = (state != IDLE) && (presc == PRESC_MAX) && (ms_cnt == ms_max);
    assign capture    = (state == WAIT_DONE) && spi_done_in;

`ifdef SCHED_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES - 1);

    logic [WW-1:0] wd_cnt;
    logic          timeout_err;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wd_cnt <= '0;
        end else if (state == WAIT_DONE && next_state == WAIT_DONE) begin
            wd_cnt <= wd_cnt + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

    // A done arriving on the expiry cycle still wins over the watchdog.
    assign timeout_hit = (state == WAIT_DONE) && !spi_done_in && (wd_cnt == WD_MAX);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            timeout_err <= 1'b0;
        end else if (clr_err_in) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end
    end

    assign timeout_err_out = timeout_err;
`else
    assign timeout_hit     = 1'b0;
    assign timeout_err_out = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (en_in) next_state = WAIT_TICK;
            end
            WAIT_TICK: begin
                if (!en_in)    next_state = IDLE;
                else if (tick) next_state = START;
            end
            START: begin
                if (!spi_busy_in) next_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (capture || timeout_hit) next_state = en_in ? WAIT_TICK : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        spi_start_out = 1'b0;
        if (state == START && !spi_busy_in) spi_start_out = 1'b1;
    end

    // Time base is cleared whenever the scheduler is (or is about to be) idle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            presc  <= '0;
            ms_cnt <= '0;
        end else if (state == IDLE || next_state == IDLE) begin
            presc  <= '0;
            ms_cnt <= '0;
        end else if (presc == PRESC_MAX) begin
            presc  <= '0;
            ms_cnt <= (ms_cnt == ms_max) ? 16'd0 : ms_cnt + 16'd1;
        end else begin
            presc  <= presc + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ms_max <= '0;
        end else if ((state == IDLE && en_in) || tick) begin
            ms_max <= period_max;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sample_out       <= '0;
            sample_valid_out <= 1'b0;
        end else begin
            sample_valid_out <= capture;
            if (capture) sample_out <= spi_data_in;
        end
    end

    // Missed ticks are dropped, only flagged.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            overrun_out <= 1'b0;
        end else if (clr_err_in) begin
            overrun_out <= 1'b0;
        end else if (tick && (state == START || state == WAIT_DONE)) begin
            overrun_out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_temp_sample_scheduler.sv
// tb/tb_temp_sample_scheduler.sv - directed self-checking bench for temp_sample_scheduler
module tb_temp_sample_scheduler;

    localparam int DW = 16;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          en_in;
    logic [15:0]   period_ms_in;
    logic          spi_start_out;
    logic          spi_busy_in;
    logic          spi_done_in;
    logic [DW-1:0] spi_data_in;
    logic [DW-1:0] sample_out;
    logic          sample_valid_out;
    logic          overrun_out;
    logic          timeout_err_out;
    logic          clr_err_in;

    int cyc = 0;
    int t0 = 0;
    int vec_cnt = 0;
    int miscompares = 0;
    int at;

    temp_sample_scheduler #(
        .CLK_FREQ_HZ    (1_000_000),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .en_in            (en_in),
        .period_ms_in     (period_ms_in),
        .spi_start_out    (spi_start_out),
        .spi_busy_in      (spi_busy_in),
        .spi_done_in      (spi_done_in),
        .spi_data_in      (spi_data_in),
        .sample_out       (sample_out),
        .sample_valid_out (sample_valid_out),
        .overrun_out      (overrun_out),
        .timeout_err_out  (timeout_err_out),
        .clr_err_in       (clr_err_in)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0; en_in = 1'b0; period_ms_in = 16'd2; spi_busy_in = 1'b0;
        spi_done_in = 1'b0; spi_data_in = '0; clr_err_in = 1'b0;
        repeat (3) step();
        rst_n_in = 1'b1;
        step();
    endtask

    task automatic enable(input logic [15:0] p);
        period_ms_in = p;
        en_in = 1'b1;
        step();
        t0 = cyc;
    endtask

    task automatic wait_until(input int rel);
        while (cyc - t0 < rel) step();
    endtask

    task automatic wait_start(input int limit, output int when);
        int n = 0;
        when = -1;
        while (n < limit) begin
            if (spi_start_out) begin
                when = cyc - t0;
                break;
            end
            step();
            n++;
        end
    endtask

    task automatic serve(input int dly, input logic [DW-1:0] d);
        step();
        check("start_one_cycle", spi_start_out, 1'b0);
        repeat (dly - 1) step();
        spi_done_in = 1'b1;
        spi_data_in = d;
        step();
        spi_done_in = 1'b0;
        spi_data_in = 16'hDEAD;
    endtask

    initial begin
        do_reset();
        check("rst_start", spi_start_out, 1'b0);
        check("rst_valid", sample_valid_out, 1'b0);
        check("rst_sample", sample_out, 16'h0);
        check("rst_overrun", overrun_out, 1'b0);
        check("rst_timeout", timeout_err_out, 1'b0);

        // Nominal 2 ms period
        enable(16'd2);
        for (int k = 1; k <= 3; k++) begin
            wait_start(2500, at);
            check("s1_start_time", at, 2000 * k);
            serve(5, 16'h0123);
            check("s1_valid", sample_valid_out, 1'b1);
            check("s1_sample", sample_out, 16'h0123);
            step();
            check("s1_valid_drop", sample_valid_out, 1'b0);
        end
        check("s1_no_overrun", overrun_out, 1'b0);

        // Period 0 acts as 1 ms
        do_reset();
        enable(16'd0);
        for (int k = 1; k <= 2; k++) begin
            wait_start(1500, at);
            check("s2_start_time", at, 1000 * k);
            serve(3, 16'h0456 + 16'(k));
            check("s2_sample", sample_out, 16'h0456 + 16'(k));
        end

        // Busy stall at tick, grid preserved
        do_reset();
        enable(16'd2);
        wait_start(2500, at);
        check("s3_first", at, 2000);
        serve(5, 16'h1111);
        wait_until(3999);
        spi_busy_in = 1'b1;
        wait_until(4050);
        check("s3_stalled", spi_start_out, 1'b0);
        spi_busy_in = 1'b0;
        #1;
        wait_start(100, at);
        check("s3_delayed", at, 4050);
        serve(5, 16'h2222);
        check("s3_sample", sample_out, 16'h2222);
        wait_start(2500, at);
        check("s3_grid", at, 6000);
        check("s3_no_overrun", overrun_out, 1'b0);

`ifndef SCHED_TIMEOUT_EN
        // Withheld done across a tick: overrun and dropped tick
        do_reset();
        enable(16'd2);
        wait_start(2500, at);
        check("s4_first", at, 2000);
        serve(2500, 16'h3333);
        check("s4_overrun", overrun_out, 1'b1);
        check("s4_sample", sample_out, 16'h3333);
        check("s4_no_timeout", timeout_err_out, 1'b0);
        wait_start(2500, at);
        check("s4_dropped_tick", at, 6000);
        serve(5, 16'h4444);
        check("s4_overrun_sticky", overrun_out, 1'b1);
        clr_err_in = 1'b1;
        step();
        clr_err_in = 1'b0;
        check("s4_overrun_clr", overrun_out, 1'b0);
`else
        // Watchdog expiry after 100 cycles in WAIT_DONE
        do_reset();
        enable(16'd2);
        wait_start(2500, at);
        check("s5_first", at, 2000);
        wait_until(2100);
        check("s5_before_timeout", timeout_err_out, 1'b0);
        step();
        check("s5_timeout", timeout_err_out, 1'b1);
        wait_until(2150);
        spi_done_in = 1'b1;
        spi_data_in = 16'h0BAD;
        step();
        spi_done_in = 1'b0;
        check("s5_late_done_valid", sample_valid_out, 1'b0);
        check("s5_late_done_sample", sample_out, 16'h0);
        wait_start(2500, at);
        check("s5_next_start", at, 4000);
        clr_err_in = 1'b1;
        step();
        clr_err_in = 1'b0;
        check("s5_timeout_clr", timeout_err_out, 1'b0);
`endif

        // Disable while in WAIT_DONE
        do_reset();
        enable(16'd1);
        wait_start(1500, at);
        check("s6_first", at, 1000);
        en_in = 1'b0;
        serve(5, 16'hBEEF);
        check("s6_valid", sample_valid_out, 1'b1);
        check("s6_sample", sample_out, 16'hBEEF);
        wait_start(1500, at);
        check("s6_no_more_start", at, -1);
        check("s6_sample_held", sample_out, 16'hBEEF);

        // Asynchronous reset mid-transaction
        enable(16'd1);
        wait_start(1500, at);
        check("s7_first", at, 1000);
        wait_until(1003);
        rst_n_in = 1'b0;
        #1;
        check("s7_rst_start", spi_start_out, 1'b0);
        check("s7_rst_valid", sample_valid_out, 1'b0);
        check("s7_rst_sample", sample_out, 16'h0);
        check("s7_rst_overrun", overrun_out, 1'b0);
        check("s7_rst_timeout", timeout_err_out, 1'b0);
        en_in = 1'b0;
        step();
        rst_n_in = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
